// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU command driver.
//   - alu_op_e  : 2-bit opcode understood by the combinational ALU
//   - alu_cmd_t : {op, a, b} command record (layout at the default width)
//   - state_e   : issue/capture sequencer states of alu_cmd_driver
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  // The driver itself is width-parameterised and stores commands as the flat
  // concatenation {op, a, b}; this record names that same layout.
  typedef struct packed {
    alu_op_e            op;
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_driver_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
//   Synchronous command FIFO holding flat {op, a, b} records.
//   Ports:
//     clk, nreset   clock, asynchronous active-low reset
//     push, din     write request / data (ignored while full)
//     pop, dout     read request (ignored while empty) / head entry
//     full, empty   occupancy flags
//     count         occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       push,
  input  logic [2+2*W-1:0]           din,
  input  logic                       pop,
  output logic [2+2*W-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int DW = 2 + 2 * W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; only entries between
  // rd_ptr and wr_ptr are ever read, and that range is empty after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//   Initiator for a combinational 2-bit-opcode ALU. Commands arrive on a
//   valid/ready stream, are queued, issued one at a time on registered
//   alu_op/a/b, and each result is returned in order on a valid/ready stream.
//   Ports:
//     clk, nreset                      clock, asynchronous active-low reset
//     cmd_valid/ready, cmd_op/a/b      command stream
//     alu_op/a/b (out), alu_out (in)   ALU operand bus and its result
//     rsp_valid/ready, rsp_data/op/zero response stream
//     count                            queued commands, 0..DEPTH
// ---------------------------------------------------------------------------
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [W-1:0]            cmd_a,
  input  logic [W-1:0]            cmd_b,
  output logic [1:0]              alu_op,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  input  logic [W-1:0]            alu_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_data,
  output logic [1:0]              rsp_op,
  output logic                    rsp_zero,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int DW = 2 + 2 * W;

  state_e        state_q;
  state_e        state_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          pop;
  logic          capture;
  logic          rsp_clear;

  // A full FIFO refuses a push even when a pop frees a slot that same cycle.
  assign cmd_ready = !fifo_full;

  cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (cmd_valid),
    .din    ({cmd_op, cmd_a, cmd_b}),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // update from pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: default assignment first, so no path through the case leaves
  // state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = fifo_empty ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes: pop loads the ALU bus, capture samples the ALU result,
  // rsp_clear retires the held response on its handshake.
  always_comb begin
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_clear = 1'b0;
    case (state_q)
      IDLE:  pop = !fifo_empty;
      ISSUE: capture = 1'b1;
      HOLD: begin
        if (rsp_ready) begin
          rsp_clear = 1'b1;
          pop       = !fifo_empty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      // The ALU bus only moves on a pop, otherwise it holds the last command.
      if (pop) {alu_op, alu_a, alu_b} <= fifo_dout;
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_op    <= alu_op;
        rsp_zero  <= (alu_out == '0);
        rsp_valid <= 1'b1;
      end else if (rsp_clear) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
//   Self-checking bench for alu_cmd_driver with a combinational ALU attached.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_op;
  logic         rsp_zero;
  logic [2:0]   count;

  always #5 clk = ~clk;

  alu_cmd_driver #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .rsp_zero  (rsp_zero),
    .count     (count)
  );

  // Combinational ALU seen by the driver.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      2'd0:    alu_out = alu_a + alu_b;
      2'd1:    alu_out = alu_a - alu_b;
      2'd2:    alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  int errors = 0;
  int checks = 0;
  int n_rsp  = 0;

  alu_cmd_t   exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic [1:0] hold_op;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
  } vec_t;
  vec_t vecs[7];

  int         t_q[$];
  logic [7:0] d_q[$];
  logic       z_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference ALU from the opcode definitions, using modulo-256 integer math.
  function automatic logic [7:0] ref_alu(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (op)
      OP_ADD:  s = (int'(a) + int'(b)) % 256;
      OP_SUB:  s = (int'(a) - int'(b) + 256) % 256;
      OP_AND:  s = int'(a & b);
      default: s = int'(a | b);
    endcase
    return 8'(s);
  endfunction

  task automatic score_rsp();
    alu_cmd_t   c;
    logic [7:0] r;
    if (exp_q.size() == 0) begin
      check("unexpected_rsp", 32'(exp_q.size()), 1);
    end else begin
      c = exp_q.pop_front();
      r = ref_alu(c.op, c.a, c.b);
      check("sb_data", 32'(rsp_data), 32'(r));
      check("sb_op",   32'(rsp_op),   32'(c.op));
      check("sb_zero", 32'(rsp_zero), 32'(r == 8'd0));
    end
  endtask

  // Scoreboard: records accepted commands, checks each response in order and
  // checks that a stalled response does not move.
  always @(negedge clk) begin
    if (!nreset) begin
      exp_q.delete();
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(rsp_valid), 1);
        check("hold_data",  32'(rsp_data),  32'(hold_data));
        check("hold_op",    32'(rsp_op),    32'(hold_op));
      end
      if (cmd_valid && cmd_ready)
        exp_q.push_back('{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b});
      if (rsp_valid && rsp_ready) begin
        n_rsp <= n_rsp + 1;
        score_rsp();
      end
      hold_pend <= rsp_valid && !rsp_ready;
      hold_data <= rsp_data;
      hold_op   <= rsp_op;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    int n    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!done) begin
      @(negedge clk);
      done = cmd_ready;
      step();
      n++;
      if (!done && n >= 200) begin
        check("send_timeout", 32'(cmd_ready), 1);
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // Wait for a response with rsp_ready high and return its fields.
  task automatic get_rsp(output logic [7:0] d, output logic [1:0] op, output logic z);
    int n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 32'(rsp_valid), 1);
    d  = rsp_data;
    op = rsp_op;
    z  = rsp_zero;
    step();
  endtask

  task automatic drain(input string name);
    int n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    check({name, "_queue_empty"}, 32'(exp_q.size()), 0);
    check({name, "_count"},       32'(count), 0);
    check({name, "_rsp_valid"},   32'(rsp_valid), 0);
  endtask

  initial begin
    int         rsp0;
    logic [7:0] d;
    logic [1:0] op;
    logic       z;
    bit         soak_done;

    vecs[0] = '{op: 2'd1, a: 8'h00, b: 8'h01, res: 8'hFF, zero: 1'b0};
    vecs[1] = '{op: 2'd2, a: 8'hF0, b: 8'h0F, res: 8'h00, zero: 1'b1};
    vecs[2] = '{op: 2'd3, a: 8'hA0, b: 8'h05, res: 8'hA5, zero: 1'b0};
    vecs[3] = '{op: 2'd0, a: 8'h01, b: 8'h01, res: 8'h02, zero: 1'b0};
    vecs[4] = '{op: 2'd0, a: 8'h02, b: 8'h02, res: 8'h04, zero: 1'b0};
    vecs[5] = '{op: 2'd0, a: 8'h03, b: 8'h03, res: 8'h06, zero: 1'b0};
    vecs[6] = '{op: 2'd0, a: 8'hFF, b: 8'h01, res: 8'h00, zero: 1'b1};

    // Reset state.
    repeat (2) step();
    check("rst_count",     32'(count), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_alu_bus",   32'({alu_op, alu_a, alu_b}), 0);
    check("rst_rsp_bus",   32'({rsp_data, rsp_op, rsp_zero}), 0);
    nreset = 1'b1;
    step();

    // Reset while holding a response with three commands queued.
    rsp_ready = 1'b0;
    send(2'd0, 8'h11, 8'h22);
    send(2'd1, 8'h33, 8'h01);
    send(2'd3, 8'h40, 8'h04);
    send(2'd2, 8'h7F, 8'h0F);
    check("t1_count_before", 32'(count), 3);
    check("t1_valid_before", 32'(rsp_valid), 1);
    nreset = 1'b0;
    step();
    check("t1_count",     32'(count), 0);
    check("t1_rsp_valid", 32'(rsp_valid), 0);
    check("t1_cmd_ready", 32'(cmd_ready), 1);
    check("t1_alu_op",    32'(alu_op), 0);
    check("t1_alu_a",     32'(alu_a), 0);
    check("t1_alu_b",     32'(alu_b), 0);
    nreset    = 1'b1;
    rsp_ready = 1'b1;
    rsp0      = n_rsp;
    repeat (10) step();
    check("t1_no_rsp_after_reset", 32'(n_rsp - rsp0), 0);
    check("t1_count_after", 32'(count), 0);

    // Single ADD: latency from acceptance to rsp_valid.
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_a     = 8'h05;
    cmd_b     = 8'h03;
    step();
    cmd_valid = 1'b0;
    check("t2_count_n",     32'(count), 1);
    check("t2_valid_n",     32'(rsp_valid), 0);
    step();
    check("t2_issue_bus",   32'({alu_op, alu_a, alu_b}), 32'({2'd0, 8'h05, 8'h03}));
    check("t2_valid_n1",    32'(rsp_valid), 0);
    step();
    check("t2_valid_n2",    32'(rsp_valid), 1);
    check("t2_data",        32'(rsp_data), 32'h08);
    check("t2_op",          32'(rsp_op), 0);
    check("t2_zero",        32'(rsp_zero), 0);
    repeat (2) step();

    // SUB / AND / OR, one at a time, in order.
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      get_rsp(d, op, z);
      check($sformatf("t3_data_%0d", i), 32'(d), 32'(vecs[i].res));
      check($sformatf("t3_op_%0d", i),   32'(op), 32'(vecs[i].op));
      check($sformatf("t3_zero_%0d", i), 32'(z), 32'(vecs[i].zero));
    end
    repeat (2) step();

    // Back-to-back ADDs: one response every second cycle.
    rsp_ready = 1'b1;
    t_q.delete();
    d_q.delete();
    z_q.delete();
    fork
      begin
        for (int i = 3; i < 7; i++) send(vecs[i].op, vecs[i].a, vecs[i].b);
      end
      begin
        for (int cyc = 0; cyc < 30; cyc++) begin
          @(negedge clk);
          if (rsp_valid) begin
            t_q.push_back(cyc);
            d_q.push_back(rsp_data);
            z_q.push_back(rsp_zero);
          end
        end
      end
    join
    check("t5_rsp_count", 32'(t_q.size()), 4);
    if (t_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t5_data_%0d", i), 32'(d_q[i]), 32'(vecs[i+3].res));
        check($sformatf("t5_zero_%0d", i), 32'(z_q[i]), 32'(vecs[i+3].zero));
        if (i > 0) check($sformatf("t5_gap_%0d", i), 32'(t_q[i] - t_q[i-1]), 2);
      end
    end
    step();

    // Backpressure: six commands against a stalled consumer.
    rsp_ready = 1'b0;
    rsp0      = n_rsp;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
      begin
        repeat (8) step();
        check("t4_count_full", 32'(count), 4);
        check("t4_cmd_ready",  32'(cmd_ready), 0);
        check("t4_rsp_valid",  32'(rsp_valid), 1);
        if (exp_q.size() > 0)
          check("t4_first_data", 32'(rsp_data), 32'(ref_alu(exp_q[0].op, exp_q[0].a, exp_q[0].b)));
        d = rsp_data;
        repeat (3) step();
        check("t4_data_stable", 32'(rsp_data), 32'(d));
        check("t4_count_still", 32'(count), 4);
        rsp_ready = 1'b1;
      end
    join
    drain("t4");
    check("t4_rsp_total", 32'(n_rsp - rsp0), 6);

    // Full FIFO with a push offered on the HOLD handshake cycle.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd0, 8'(i + 1), 8'h10);
    check("t6_count_full", 32'(count), 4);
    check("t6_holding",    32'(rsp_valid), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_a     = 8'h0C;
    cmd_b     = 8'h30;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_refused", 32'(cmd_ready), 0);
    step();
    check("t6_count_pop", 32'(count), 3);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t6_ready_next", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    check("t6_count_push", 32'(count), 4);
    drain("t6");

    // Randomised traffic against the scoreboard.
    rsp0      = n_rsp;
    soak_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain("soak");
    check("soak_rsp_total", 32'(n_rsp - rsp0), 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
